// File: rtl/io_pkg.sv
// io_pkg: register offsets and bit positions shared by the IO/timer block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package io_pkg;

    // Register offsets, selected by addr[4:2]
    localparam logic [2:0] OFS_LED    = 3'd0;
    localparam logic [2:0] OFS_SW     = 3'd1;
    localparam logic [2:0] OFS_CTRL   = 3'd2;
    localparam logic [2:0] OFS_LOAD   = 3'd3;
    localparam logic [2:0] OFS_COUNT  = 3'd4;
    localparam logic [2:0] OFS_STATUS = 3'd5;

    // CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_TIE  = 2;
    localparam int CTRL_SIE  = 3;
    localparam int CTRL_W    = 4;

    // STATUS bit indices
    localparam int ST_TEXP  = 0;
    localparam int ST_SWCHG = 1;
    localparam int ST_W     = 2;

    // Width of a counter holding 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: one switch bit -> 2-flop synchroniser -> optional stability filter.
// Latency: 2 cycles without filter; 2 + DEB_CYCLES cycles with IO_DEBOUNCE_EN.
// Backpressure: none; chg_o pulses for one cycle on the edge where sw_o changes.
//
// Ports: clk, rst (async active-low), sw_i raw async switch,
//        sw_o accepted switch level, chg_o = sw_o will change on the next edge.
// Build option: IO_DEBOUNCE_EN enables the DEB_CYCLES stability counter.
module io_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic sw_o,
    output logic chg_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = sw_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          st_q, st_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any bounce back to the accepted level restarts it.
    always_comb begin
        cnt_d = cnt_q;
        st_d  = st_q;
        chg_o = 1'b0;
        if (s2_q == st_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            st_d  = s2_q;
            cnt_d = '0;
            chg_o = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            st_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

    assign sw_o = st_q;
`else
    // Filter removed: the second sync stage is the accepted level, and it is
    // about to change whenever the two stages disagree.
    logic unused_deb;
    assign unused_deb = ^DEB_CYCLES;
    assign sw_o  = s2_q;
    assign chg_o = s1_q ^ s2_q;
`endif

endmodule

// File: rtl/io_timer_ctrl.sv
// io_timer_ctrl: MIOC IO slave with LED register, debounced switches, prescaled down-timer, W1C status.
// Latency: writes land on the ce&we edge; reads combinational; intimer/irq one cycle after status.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Ports: clk, rst (async active-low); ce/we/addr/wtData/rdData bus from MIOC
//        (addr[4:2] selects the register); sw raw switches; led registered LED
//        drive; intimer = TEXP&TIE; irq = intimer | SWCHG&SIE (both registered).
// Build option: IO_DEBOUNCE_EN adds the per-bit stability counter in io_debounce.
module io_timer_ctrl
    import io_pkg::*;
#(
    parameter int LED_W      = 16,
    parameter int SW_W       = 1,
    parameter int CNT_W      = 32,
    parameter int PRESCALE   = 1,
    parameter int DEB_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wtData,
    output logic [31:0]      rdData,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             intimer,
    output logic             irq
);

    localparam int             PW      = cnt_width(PRESCALE);
    localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

    logic [2:0] sel;
    logic       wr_led, wr_ctrl, wr_load, wr_status;
    logic       unused_bus;

    assign sel        = addr[4:2];
    assign wr_led     = ce & we & (sel == OFS_LED);
    assign wr_ctrl    = ce & we & (sel == OFS_CTRL);
    assign wr_load    = ce & we & (sel == OFS_LOAD);
    assign wr_status  = ce & we & (sel == OFS_STATUS);
    assign unused_bus = ^{addr[31:5], addr[1:0], wtData};

    // ---------------- switch inputs ----------------
    logic [SW_W-1:0] sw_db;
    logic [SW_W-1:0] sw_chg;

    for (genvar g = 0; g < SW_W; g++) begin : g_sw
        io_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .sw_i  (sw[g]),
            .sw_o  (sw_db[g]),
            .chg_o (sw_chg[g])
        );
    end

    // ---------------- state ----------------
    logic [LED_W-1:0]  led_q, led_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  load_q, load_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [ST_W-1:0]   status_q, status_d;
    logic              intimer_q, intimer_d;
    logic              irq_q, irq_d;

    logic en_rise;
    logic tick;
    logic expire;

    // EN going 0->1 through a CTRL write restarts the countdown from LOAD.
    assign en_rise = wr_ctrl & wtData[CTRL_EN] & ~ctrl_q[CTRL_EN];
    assign tick    = ctrl_q[CTRL_EN] & (presc_q == PRE_MAX);
    assign expire  = tick & (count_q == '0);

    always_comb begin
        led_d = led_q;
        if (wr_led) begin
            led_d = wtData[LED_W-1:0];
        end

        load_d = load_q;
        if (wr_load) begin
            load_d = wtData[CNT_W-1:0];
        end

        // One-shot expiry drops EN; an explicit CTRL write on the same edge
        // takes precedence over that hardware clear.
        ctrl_d = ctrl_q;
        if (expire && !ctrl_q[CTRL_AUTO]) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = wtData[CTRL_W-1:0];
        end

        // Prescaler advances only while enabled, so clearing EN freezes it.
        presc_d = presc_q;
        if (en_rise) begin
            presc_d = '0;
        end else if (ctrl_q[CTRL_EN]) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        count_d = count_q;
        if (en_rise) begin
            count_d = load_q;
        end else if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else if (ctrl_q[CTRL_AUTO]) begin
                count_d = load_q;
            end
        end

        // W1C first, then hardware sets OR'd on top so a set always wins.
        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~wtData[ST_W-1:0];
        end
        if (expire) begin
            status_d[ST_TEXP] = 1'b1;
        end
        if (|sw_chg) begin
            status_d[ST_SWCHG] = 1'b1;
        end

        intimer_d = status_q[ST_TEXP] & ctrl_q[CTRL_TIE];
        irq_d     = intimer_d | (status_q[ST_SWCHG] & ctrl_q[CTRL_SIE]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q     <= '0;
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            presc_q   <= '0;
            status_q  <= '0;
            intimer_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            led_q     <= led_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            status_q  <= status_d;
            intimer_q <= intimer_d;
            irq_q     <= irq_d;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rdData = '0;
        if (ce) begin
            case (sel)
                OFS_LED:    rdData = 32'(led_q);
                OFS_SW:     rdData = 32'(sw_db);
                OFS_CTRL:   rdData = 32'(ctrl_q);
                OFS_LOAD:   rdData = 32'(load_q);
                OFS_COUNT:  rdData = 32'(count_q);
                OFS_STATUS: rdData = 32'(status_q);
                default:    rdData = '0;
            endcase
        end
    end

    assign led     = led_q;
    assign intimer = intimer_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_io_timer_ctrl.sv
// tb_io_timer_ctrl: self-checking bench for io_timer_ctrl (PRESCALE=1 and PRESCALE=4 instances).
// Latency: inputs driven at the falling edge, outputs sampled just after it.
// Backpressure: n/a.
module tb_io_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we;
    logic [31:0] addr, wtData;
    logic [31:0] rdData, rdData4;
    logic [0:0]  sw;
    logic [15:0] led, led4;
    logic        intimer, irq, intimer4, irq4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

`ifdef IO_DEBOUNCE_EN
    localparam int SW_LAT = 7;
`else
    localparam int SW_LAT = 2;
`endif

    always #5 clk = ~clk;

    io_timer_ctrl #(.LED_W(16), .SW_W(1), .CNT_W(32), .PRESCALE(1), .DEB_CYCLES(5)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wtData(wtData),
        .rdData(rdData), .sw(sw), .led(led), .intimer(intimer), .irq(irq));

    io_timer_ctrl #(.LED_W(16), .SW_W(1), .CNT_W(32), .PRESCALE(4), .DEB_CYCLES(5)) u_dut4 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wtData(wtData),
        .rdData(rdData4), .sw(sw), .led(led4), .intimer(intimer4), .irq(irq4));

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns at the following falling edge.
    task automatic wr(input logic [2:0] ofs, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = {27'h0, ofs, 2'b00}; wtData = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; wtData = '0;
    endtask

    task automatic rd(input logic [2:0] ofs, output logic [31:0] d, output logic [31:0] d4);
        ce = 1'b1; we = 1'b0; addr = {27'h0, ofs, 2'b00};
        #1;
        d = rdData; d4 = rdData4;
        ce = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wtData = '0; sw = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] d, d4;
        do_reset();
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL rst_led: got %h exp 0000", led); end
        n_checks++; if (intimer !== 1'b0) begin n_fail++; $display("FAIL rst_intimer: got %b exp 0", intimer); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b exp 0", irq); end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d, d4);
            n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_reg%0d: got %h exp 00000000", i, d); end
        end
    endtask

    task automatic test_led();
        logic [31:0] d, d4;
        do_reset();
        wr(3'd0, 32'h0000A5A5);
        n_checks++; if (led !== 16'hA5A5) begin n_fail++; $display("FAIL led_out: got %h exp a5a5", led); end
        rd(3'd0, d, d4);
        n_checks++; if (d !== 32'h0000A5A5) begin n_fail++; $display("FAIL led_rd: got %h exp 0000a5a5", d); end
        wr(3'd6, 32'hFFFFFFFF);
        rd(3'd6, d, d4);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h exp 00000000", d); end
        rd(3'd0, d, d4);
        n_checks++; if (d !== 32'h0000A5A5) begin n_fail++; $display("FAIL led_keep: got %h exp 0000a5a5", d); end
        ce = 1'b0; we = 1'b0; addr = '0; #1;
        n_checks++; if (rdData !== 32'h0) begin n_fail++; $display("FAIL rd_no_ce: got %h exp 00000000", rdData); end
        ce = 1'b1; addr = 32'hFFFF_FFE3; #1;
        n_checks++; if (rdData !== 32'h0000A5A5) begin n_fail++; $display("FAIL rd_addr_hi: got %h exp 0000a5a5", rdData); end
        ce = 1'b0; addr = '0;
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] d, d4, e;
        do_reset();
        wr(3'd3, 32'd3);
        wr(3'd2, 32'h5);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(3 - k));
        for (int k = 0; k < 4; k++) begin
            rd(3'd4, d, d4);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL oneshot_cnt%0d: got %h exp %h", k, d, e); end
            step();
        end
        rd(3'd5, d, d4);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL oneshot_texp: got %h exp 00000001", d); end
        n_checks++; if (intimer !== 1'b0) begin n_fail++; $display("FAIL oneshot_int_early: got %b exp 0", intimer); end
        step();
        n_checks++; if (intimer !== 1'b1) begin n_fail++; $display("FAIL oneshot_int: got %b exp 1", intimer); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b exp 1", irq); end
        rd(3'd2, d, d4);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL oneshot_en_clr: got %h exp 00000004", d); end
        step();
        rd(3'd4, d, d4);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL oneshot_hold: got %h exp 00000000", d); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d, d4, e;
        do_reset();
        wr(3'd3, 32'd2);
        wr(3'd2, 32'h7);
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(32'(2 - (k % 3)));
            exp_q.push_back((k >= 3) ? 32'h1 : 32'h0);
            rd(3'd4, d, d4);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL auto_cnt%0d: got %h exp %h", k, d, e); end
            rd(3'd5, d, d4);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL auto_st%0d: got %h exp %h", k, d, e); end
            step();
        end
        wr(3'd5, 32'h1);
        rd(3'd5, d, d4);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h exp 00000000", d); end
        step();
        n_checks++; if (intimer !== 1'b0) begin n_fail++; $display("FAIL w1c_int_drop: got %b exp 0", intimer); end
        rd(3'd4, d, d4);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL pre_coinc_cnt: got %h exp 00000000", d); end
        wr(3'd5, 32'h1);
        rd(3'd5, d, d4);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL set_wins: got %h exp 00000001", d); end
        wr(3'd2, 32'h6);
        rd(3'd4, d, d4);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL freeze_cnt: got %h exp 00000001", d); end
        repeat (3) step();
        rd(3'd4, d, d4);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL freeze_hold: got %h exp 00000001", d); end
    endtask

    task automatic test_prescale();
        logic [31:0] d, d4, e;
        do_reset();
        wr(3'd3, 32'd1);
        wr(3'd2, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_q.push_back((k >= 4) ? 32'h0 : 32'h1);
            exp_q.push_back((k >= 8) ? 32'h1 : 32'h0);
            rd(3'd4, d, d4);
            e = exp_q.pop_front();
            n_checks++; if (d4 !== e) begin n_fail++; $display("FAIL pre_cnt%0d: got %h exp %h", k, d4, e); end
            rd(3'd5, d, d4);
            e = exp_q.pop_front();
            n_checks++; if (d4 !== e) begin n_fail++; $display("FAIL pre_texp%0d: got %h exp %h", k, d4, e); end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d, d4, e;
        do_reset();
        wr(3'd2, 32'h8);
`ifdef IO_DEBOUNCE_EN
        sw = 1'b1;
        repeat (3) step();
        sw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rd(3'd1, d, d4);
            n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_sw%0d: got %h exp 00000000", k, d); end
            rd(3'd5, d, d4);
            n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_st%0d: got %h exp 00000000", k, d); end
            step();
        end
`endif
        sw = 1'b1;
        for (int k = 0; k <= SW_LAT; k++) begin
            step();
            exp_q.push_back((k >= SW_LAT - 1) ? 32'h1 : 32'h0);
            exp_q.push_back((k >= SW_LAT - 1) ? 32'h2 : 32'h0);
            exp_q.push_back((k >= SW_LAT) ? 32'h1 : 32'h0);
            rd(3'd1, d, d4);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL sw_val%0d: got %h exp %h", k, d, e); end
            rd(3'd5, d, d4);
            e = exp_q.pop_front();
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL swchg%0d: got %h exp %h", k, d, e); end
            e = exp_q.pop_front();
            n_checks++; if (32'(irq) !== e) begin n_fail++; $display("FAIL sw_irq%0d: got %b exp %h", k, irq, e); end
        end
        n_checks++; if (intimer !== 1'b0) begin n_fail++; $display("FAIL sw_intimer: got %b exp 0", intimer); end
        sw = 1'b0;
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d, d4;
        do_reset();
        wr(3'd0, 32'h1234);
        wr(3'd3, 32'd5);
        wr(3'd2, 32'h7);
        for (int i = 0; i < 40 && intimer !== 1'b1; i++) step();
        n_checks++; if (intimer !== 1'b1) begin n_fail++; $display("FAIL mid_wait_int: got %b exp 1", intimer); end
        rd(3'd4, d, d4);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL mid_cnt: got %h exp 00000004", d); end
        rst = 1'b0;
        #1;
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL arst_led: got %h exp 0000", led); end
        n_checks++; if (intimer !== 1'b0) begin n_fail++; $display("FAIL arst_int: got %b exp 0", intimer); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %b exp 0", irq); end
        rd(3'd4, d, d4);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL arst_cnt: got %h exp 00000000", d); end
        rd(3'd5, d, d4);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL arst_st: got %h exp 00000000", d); end
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_led();
        test_timer_oneshot();
        test_auto_reload();
        test_prescale();
        test_debounce();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_timer_ctrl.md
Name: io_timer_ctrl

Overview:
- Parametrised successor to the SoC IO block; sits behind MIOC on the ioCe/ioWe/ioAddr/ioWtData/ioRdData path.
- Provides a LED_W-bit LED output register and SW_W debounced switch inputs.
- Adds a programmable down-counting timer with prescaler and auto-reload.
- Drives the intimer line into MIPS intr[0] plus an aggregate irq, using a write-one-to-clear (W1C) status register.

Parameters:
- LED_W, 16, LED register / led port width (1..32)
- SW_W, 1, switch input count (1..32)
- CNT_W, 32, timer counter width (8..32)
- PRESCALE, 1, clk cycles per timer tick (>=1)
- DEB_CYCLES, 1000, cycles a synchronised switch must be stable before it is accepted

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ce  in  1  IO select from MIOC
- we  in  1  write enable (valid when ce=1)
- addr  in  32  byte address; addr[4:2] selects the register, other bits ignored
- wtData  in  32  write data
- rdData  out  32  read data, combinational
- sw  in  SW_W  raw asynchronous switches
- led  out  LED_W  LED drive, registered
- intimer  out  1  timer interrupt level
- irq  out  1  OR of all enabled pending interrupts

Behaviour:
- Reset (rst=0, async): all registers cleared; led=0, intimer=0, irq=0, timer count=0, prescaler=0, switch state=0.
- Writes take effect on the rising clk edge when ce&we. Reads are combinational: rdData = selected register, zero-extended; rdData=0 when ce=0 or the offset is unmapped.
- Register map, selected by addr[4:2]:
  - 0 LED (RW): low LED_W bits drive led.
  - 1 SW (RO): debounced switch state.
  - 2 CTRL (RW): bit0 EN, bit1 AUTO, bit2 TIE (timer interrupt enable), bit3 SIE (switch interrupt enable).
  - 3 LOAD (RW, CNT_W bits).
  - 4 COUNT (RO).
  - 5 STATUS (W1C): bit0 TEXP, bit1 SWCHG.
  - 6, 7: unmapped; reads 0, writes ignored.
- Timer:
  - EN rising 0->1 (by write): COUNT<=LOAD and prescaler<=0 on the same edge.
  - Tick: prescaler counts 0..PRESCALE-1; a tick occurs when it wraps.
  - Each tick with EN=1: if COUNT!=0, COUNT-1.
  - If COUNT==0 at a tick: TEXP<=1. Then if AUTO=1, COUNT<=LOAD; otherwise EN<=0 and COUNT holds at 0.
  - LOAD=0 with AUTO=1: expires every tick.
  - A LOAD write while running does not affect COUNT until the next reload.
  - EN cleared by write: COUNT and prescaler freeze.
- Switch path:
  - 2-flop synchroniser, then per-bit debounce (see Optional Feature).
  - Any accepted SW change sets SWCHG.
- Status:
  - Writing 1 to a bit clears it.
  - A hardware set in the same cycle as a W1C of that bit: set wins, bit stays 1.
- Interrupt outputs, registered and updated the cycle after the status change:
  - intimer = TEXP & TIE
  - irq = intimer | (SWCHG & SIE)
- Latency: write to led visible 1 cycle after the edge; TEXP is set on the edge where COUNT==0 coincides with a tick.
- Reset mid-count: everything returns to reset values immediately; no pending interrupt survives.

Optional Feature:
- Macro IO_DEBOUNCE_EN.
- Defined: each synchronised switch bit feeds a stability counter (width clog2(DEB_CYCLES+1)). The SW bit updates only after the input has been stable for DEB_CYCLES consecutive cycles; any change resets the counter.
- Undefined: SW = 2-flop synchronised input directly (latency 2 cycles), the counter logic is removed, and DEB_CYCLES is ignored.

Decomposition:
- Package io_pkg holds:
  - register offset constants (OFS_LED=0, OFS_SW=1, OFS_CTRL=2, OFS_LOAD=3, OFS_COUNT=4, OFS_STATUS=5)
  - CTRL bit-index constants (EN=0, AUTO=1, TIE=2, SIE=3)
  - STATUS bit-index constants (TEXP=0, SWCHG=1)
- Sub-module io_debounce (one instance per switch bit via generate): synchroniser plus optional stability counter.

Test Plan:
- Reset, then write LED=0x0000A5A5 at offset 0 -> led=16'hA5A5 next cycle; read offset 0 returns 0x0000A5A5; read offset 6 returns 0.
- PRESCALE=1, LOAD=3, CTRL=0x5 (EN, TIE, no AUTO) -> COUNT reads 3,2,1,0; TEXP set on the following edge; intimer=1 one cycle later; EN auto-clears and COUNT holds 0.
- LOAD=2, CTRL=0x7 (AUTO) -> TEXP every 3 ticks; write STATUS=1 -> intimer drops; a W1C in the same cycle as an expiry leaves TEXP=1.
- PRESCALE=4, LOAD=1, EN -> expiry exactly 8 clk cycles after the enable write.
- IO_DEBOUNCE_EN, DEB_CYCLES=5: sw glitches 0->1 for 3 cycles -> SW stays 0 and SWCHG stays 0; sw held 1 -> SW=1 after 2+5 cycles and SWCHG=1; with SIE=1, irq=1.
- Assert rst=0 mid-count with intimer=1 -> led, COUNT, STATUS, intimer and irq are all 0 immediately, without waiting for a clock edge.
